decode_issue_buffer: RTL and testbench

- Parametrised successor of the ID stage. A DEPTH-entry instruction buffer decouples fetch from decode.
- Contains an NREGS x XLEN register file with write-through bypass.
- Drives a registered ID/EX bundle. Honours hazard, stall_mem and flush.
- Sits between fetch and the instruction decoder/EX stage.

---
 rtl/decode_issue_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_decode_issue_buffer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_buffer.sv
// decode_issue_buffer: DEPTH-entry fetch buffer feeding a registered ID/EX
// bundle, with an NREGS x XLEN register file and write-through bypass.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_instruction, in_curr_pc, in_next_pc
//   hazard              load-use bubble, head retained
//   stall_mem           hold ID/EX, buffer keeps accepting
//   flush               discard buffer and ID/EX contents
//   write_enable/_reg/_data  writeback port into the register file
//   out_*               registered ID/EX bundle (NOP_INSTR / zeros on bubble)
//   occupancy           buffered entry count
//   interrupt_branch_alert   head (or bypassed input) is a branch/jalr
//
// Build option: define DECODE_BUF_BYPASS_EN to let an entry arriving at an
// empty buffer load ID/EX directly (1-edge latency).

module decode_issue_buffer #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              NREGS     = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_instruction,
    input  logic [XLEN-1:0]            in_curr_pc,
    input  logic [XLEN-1:0]            in_next_pc,
    input  logic                       hazard,
    input  logic                       stall_mem,
    input  logic                       flush,
    input  logic                       write_enable,
    input  logic [$clog2(NREGS)-1:0]   write_reg,
    input  logic [XLEN-1:0]            write_data,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_instruction,
    output logic [XLEN-1:0]            out_curr_pc,
    output logic [XLEN-1:0]            out_next_pc,
    output logic [XLEN-1:0]            out_rs1_data,
    output logic [XLEN-1:0]            out_rs2_data,
    output logic [$clog2(NREGS)-1:0]   out_rs1,
    output logic [$clog2(NREGS)-1:0]   out_rs2,
    output logic [$clog2(NREGS)-1:0]   out_rd,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       interrupt_branch_alert
);

    localparam int RW = $clog2(NREGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] r_buf_instr [DEPTH];
    logic [XLEN-1:0] r_buf_cpc   [DEPTH];
    logic [XLEN-1:0] r_buf_npc   [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic [XLEN-1:0] r_rf [NREGS];

    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_cpc;
    logic [XLEN-1:0] r_npc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;

    logic            w_ready;
    logic            w_head_valid;
    logic            w_can_issue;
    logic            w_use_in;
    logic            w_byp;
    logic            w_enq;
    logic            w_load;
    logic            w_src_valid;
    logic [XLEN-1:0] w_src_instr;
    logic [XLEN-1:0] w_src_cpc;
    logic [XLEN-1:0] w_src_npc;
    logic [RW-1:0]   w_rs1;
    logic [RW-1:0]   w_rs2;
    logic [RW-1:0]   w_rd;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [6:0]      w_opcode;

    // Ready depends only on the registered count, so a full buffer never
    // refills in the same cycle it drains.
    assign w_ready      = (r_count < CW'(DEPTH));
    assign w_head_valid = (r_count != '0);
    assign w_can_issue  = w_head_valid & ~stall_mem & ~hazard & ~flush;

`ifdef DECODE_BUF_BYPASS_EN
    assign w_use_in = ~w_head_valid & in_valid;
    assign w_byp    = w_use_in & ~stall_mem & ~hazard & ~flush;
`else
    assign w_use_in = 1'b0;
    assign w_byp    = 1'b0;
`endif

    // A bypassed entry goes straight to ID/EX and is not buffered.
    assign w_enq  = in_valid & w_ready & ~flush & ~w_byp;
    assign w_load = w_can_issue | w_byp;

    assign w_src_valid = w_head_valid | w_use_in;
    assign w_src_instr = w_use_in ? in_instruction : r_buf_instr[r_rptr];
    assign w_src_cpc   = w_use_in ? in_curr_pc     : r_buf_cpc[r_rptr];
    assign w_src_npc   = w_use_in ? in_next_pc     : r_buf_npc[r_rptr];

    assign w_rs1    = w_src_instr[15 +: RW];
    assign w_rs2    = w_src_instr[20 +: RW];
    assign w_rd     = w_src_instr[7 +: RW];
    assign w_opcode = w_src_instr[6:0];

    // Write-through: a same-cycle writeback to the source register wins.
    assign w_rs1_data = (w_rs1 == '0) ? '0 :
                        (write_enable && write_reg == w_rs1) ? write_data :
                        r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 :
                        (write_enable && write_reg == w_rs2) ? write_data :
                        r_rf[w_rs2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + PW'(1);
            if (w_can_issue)
                r_rptr <= r_rptr + PW'(1);
            if (w_enq && !w_can_issue)
                r_count <= r_count + CW'(1);
            else if (!w_enq && w_can_issue)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_buf_instr[r_wptr] <= in_instruction;
            r_buf_cpc[r_wptr]   <= in_curr_pc;
            r_buf_npc[r_wptr]   <= in_next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_rf[i] <= '0;
        end else if (write_enable && write_reg != '0) begin
            r_rf[write_reg] <= write_data;
        end
    end

    // ID/EX updates on flush or when not stalled; anything not loaded
    // becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_cpc      <= '0;
            r_npc      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else if (flush || !stall_mem) begin
            r_valid    <= w_load;
            r_instr    <= w_load ? w_src_instr : NOP_INSTR;
            r_cpc      <= w_load ? w_src_cpc   : '0;
            r_npc      <= w_load ? w_src_npc   : '0;
            r_rs1_data <= w_load ? w_rs1_data  : '0;
            r_rs2_data <= w_load ? w_rs2_data  : '0;
            r_rs1      <= w_load ? w_rs1       : '0;
            r_rs2      <= w_load ? w_rs2       : '0;
            r_rd       <= w_load ? w_rd        : '0;
        end
    end

    assign in_ready        = w_ready;
    assign out_valid       = r_valid;
    assign out_instruction = r_instr;
    assign out_curr_pc     = r_cpc;
    assign out_next_pc     = r_npc;
    assign out_rs1_data    = r_rs1_data;
    assign out_rs2_data    = r_rs2_data;
    assign out_rs1         = r_rs1;
    assign out_rs2         = r_rs2;
    assign out_rd          = r_rd;
    assign occupancy       = r_count;

    assign interrupt_branch_alert = w_src_valid &
        ((w_opcode == 7'b1100011) || (w_opcode == 7'b1100111));

endmodule

// File: tb/tb_decode_issue_buffer.sv
// tb_decode_issue_buffer: directed bench for decode_issue_buffer.
// One task per scenario with inline comparisons against hand values.

module tb_decode_issue_buffer;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ADD0 = 32'h00200233;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] JALR = 32'h000080E7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_curr_pc;
    logic [31:0] in_next_pc;
    logic        hazard;
    logic        stall_mem;
    logic        flush;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_curr_pc;
    logic [31:0] out_next_pc;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  occupancy;
    logic        interrupt_branch_alert;

    int errors = 0;
    int checks = 0;

    decode_issue_buffer dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_instruction         (in_instruction),
        .in_curr_pc             (in_curr_pc),
        .in_next_pc             (in_next_pc),
        .hazard                 (hazard),
        .stall_mem              (stall_mem),
        .flush                  (flush),
        .write_enable           (write_enable),
        .write_reg              (write_reg),
        .write_data             (write_data),
        .out_valid              (out_valid),
        .out_instruction        (out_instruction),
        .out_curr_pc            (out_curr_pc),
        .out_next_pc            (out_next_pc),
        .out_rs1_data           (out_rs1_data),
        .out_rs2_data           (out_rs2_data),
        .out_rs1                (out_rs1),
        .out_rs2                (out_rs2),
        .out_rd                 (out_rd),
        .occupancy              (occupancy),
        .interrupt_branch_alert (interrupt_branch_alert)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        in_valid       = 1'b1;
        in_instruction = ins;
        in_curr_pc     = pc;
        in_next_pc     = pc + 32'd4;
        step();
        in_valid       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_occ got=%0d exp=0", occupancy);
        end
        checks++;
        if (out_valid !== 1'b0 || out_instruction !== NOP) begin
            errors++;
            $display("FAIL reset_out got=%b/%h exp=0/%h",
                     out_valid, out_instruction, NOP);
        end
        checks++;
        if (in_ready !== 1'b1 || out_curr_pc !== 32'd0 ||
            out_rs1_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_misc rdy=%b pc=%h rs1d=%h exp=1/0/0",
                     in_ready, out_curr_pc, out_rs1_data);
        end
        rst = 1'b0;
        stall_mem = 1'b1;
        push(32'h100, 32'h33);
        push(32'h104, 32'h33);
        push(32'h108, 32'h33);
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL midrst_pre_occ got=%0d exp=3", occupancy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0 ||
            out_instruction !== NOP || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst occ=%0d v=%b ins=%h rdy=%b exp=0/0/%h/1",
                     occupancy, out_valid, out_instruction, in_ready, NOP);
        end
        #1 rst = 1'b0;
        stall_mem = 1'b0;
    endtask

    task automatic test_fill_drain();
        stall_mem = 1'b1;
        for (int i = 0; i < 4; i++)
            push(32'(i * 4), 32'h33 | 32'(i << 7));
        checks++;
        if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full occ=%0d rdy=%b exp=4/0", occupancy, in_ready);
        end
        push(32'h10, 32'h33);
        checks++;
        if (occupancy !== 3'd4) begin
            errors++;
            $display("FAIL fifth_offer occ=%0d exp=4", occupancy);
        end
        stall_mem = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_curr_pc !== 32'(i * 4) ||
                out_next_pc !== 32'(i * 4 + 4) ||
                out_instruction !== (32'h33 | 32'(i << 7))) begin
                errors++;
                $display("FAIL drain%0d v=%b pc=%h npc=%h ins=%h exp pc=%h",
                         i, out_valid, out_curr_pc, out_next_pc,
                         out_instruction, i * 4);
            end
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_instruction !== NOP ||
            out_curr_pc !== 32'd0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL empty_bubble v=%b ins=%h pc=%h occ=%0d",
                     out_valid, out_instruction, out_curr_pc, occupancy);
        end
        stall_mem = 1'b1;
        push(32'h20, 32'h33);
        push(32'h24, 32'h33);
        push(32'h28, 32'h33);
        stall_mem = 1'b0;
        step();
        checks++;
        if (out_curr_pc !== 32'h20 || occupancy !== 3'd2) begin
            errors++;
            $display("FAIL wrap0 pc=%h occ=%0d exp=20/2", out_curr_pc, occupancy);
        end
        stall_mem = 1'b1;
        push(32'h2C, 32'h33);
        push(32'h30, 32'h33);
        checks++;
        if (occupancy !== 3'd4 || out_curr_pc !== 32'h20) begin
            errors++;
            $display("FAIL wrap_fill occ=%0d pc=%h exp=4/20", occupancy, out_curr_pc);
        end
        stall_mem = 1'b0;
        for (int i = 1; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_curr_pc !== 32'(32'h20 + i * 4)) begin
                errors++;
                $display("FAIL wrap%0d v=%b pc=%h exp=%h",
                         i, out_valid, out_curr_pc, 32'h20 + i * 4);
            end
        end
        step();
    endtask

    task automatic test_regfile();
        write_enable = 1'b1;
        write_reg    = 5'd1;
        write_data   = 32'd5;
        step();
        write_reg    = 5'd2;
        write_data   = 32'd7;
        step();
        write_enable = 1'b0;
        stall_mem = 1'b1;
        push(32'h200, ADD);
        stall_mem = 1'b0;
        step();
        checks++;
        if (out_rs1_data !== 32'd5 || out_rs2_data !== 32'd7) begin
            errors++;
            $display("FAIL rf_read rs1d=%0d rs2d=%0d exp=5/7",
                     out_rs1_data, out_rs2_data);
        end
        checks++;
        if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd3 ||
            out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rf_fields rs1=%0d rs2=%0d rd=%0d v=%b exp=1/2/3/1",
                     out_rs1, out_rs2, out_rd, out_valid);
        end
        stall_mem = 1'b1;
        push(32'h204, ADD);
        stall_mem    = 1'b0;
        write_enable = 1'b1;
        write_reg    = 5'd1;
        write_data   = 32'd9;
        step();
        write_enable = 1'b0;
        checks++;
        if (out_rs1_data !== 32'd9 || out_rs2_data !== 32'd7) begin
            errors++;
            $display("FAIL rf_bypass rs1d=%0d rs2d=%0d exp=9/7",
                     out_rs1_data, out_rs2_data);
        end
        write_enable = 1'b1;
        write_reg    = 5'd0;
        write_data   = 32'hFFFF;
        step();
        stall_mem = 1'b1;
        push(32'h208, ADD0);
        stall_mem = 1'b0;
        step();
        write_enable = 1'b0;
        checks++;
        if (out_rs1_data !== 32'd0 || out_rs1 !== 5'd0 ||
            out_rs2_data !== 32'd7 || out_rd !== 5'd4) begin
            errors++;
            $display("FAIL rf_x0 rs1d=%h rs1=%0d rs2d=%0d rd=%0d exp=0/0/7/4",
                     out_rs1_data, out_rs1, out_rs2_data, out_rd);
        end
    endtask

    task automatic test_hazard();
        stall_mem = 1'b1;
        push(32'h10, 32'h33);
        push(32'h14, 32'h33);
        stall_mem = 1'b0;
        hazard    = 1'b1;
        step();
        hazard    = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_instruction !== NOP ||
            occupancy !== 3'd2) begin
            errors++;
            $display("FAIL hazard_bubble v=%b ins=%h occ=%0d exp=0/%h/2",
                     out_valid, out_instruction, occupancy, NOP);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_curr_pc !== 32'h10 ||
            occupancy !== 3'd1) begin
            errors++;
            $display("FAIL hazard_issue v=%b pc=%h occ=%0d exp=1/10/1",
                     out_valid, out_curr_pc, occupancy);
        end
        step();
        checks++;
        if (out_curr_pc !== 32'h14 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL hazard_next pc=%h occ=%0d exp=14/0",
                     out_curr_pc, occupancy);
        end
    endtask

    task automatic test_flush();
        stall_mem = 1'b1;
        push(32'h40, 32'h33);
        push(32'h44, 32'h33);
        push(32'h48, 32'h33);
        checks++;
        if (occupancy !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre occ=%0d exp=3", occupancy);
        end
        flush          = 1'b1;
        hazard         = 1'b1;
        in_valid       = 1'b1;
        in_instruction = 32'h33;
        in_curr_pc     = 32'h4C;
        in_next_pc     = 32'h50;
        step();
        flush     = 1'b0;
        hazard    = 1'b0;
        in_valid  = 1'b0;
        stall_mem = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush occ=%0d v=%b rdy=%b exp=0/0/1",
                     occupancy, out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_curr_pc !== 32'd0) begin
                errors++;
                $display("FAIL flush_gone%0d v=%b pc=%h exp=0/0",
                         i, out_valid, out_curr_pc);
            end
        end
    endtask

    task automatic test_alert();
        logic exp_alert;
        stall_mem = 1'b1;
        push(32'h60, BEQ);
        checks++;
        if (interrupt_branch_alert !== 1'b1) begin
            errors++;
            $display("FAIL alert_beq got=%b exp=1", interrupt_branch_alert);
        end
        stall_mem = 1'b0;
        step();
        checks++;
        if (interrupt_branch_alert !== 1'b0 || out_instruction !== BEQ) begin
            errors++;
            $display("FAIL alert_empty got=%b ins=%h exp=0/%h",
                     interrupt_branch_alert, out_instruction, BEQ);
        end
        stall_mem = 1'b1;
        push(32'h64, JALR);
        checks++;
        if (interrupt_branch_alert !== 1'b1) begin
            errors++;
            $display("FAIL alert_jalr got=%b exp=1", interrupt_branch_alert);
        end
        push(32'h68, 32'h33);
        stall_mem = 1'b0;
        step();
        checks++;
        if (interrupt_branch_alert !== 1'b0 || out_curr_pc !== 32'h64) begin
            errors++;
            $display("FAIL alert_alu got=%b pc=%h exp=0/64",
                     interrupt_branch_alert, out_curr_pc);
        end
        step();
        in_valid       = 1'b1;
        in_instruction = BEQ;
        in_curr_pc     = 32'h80;
        in_next_pc     = 32'h84;
        #1;
`ifdef DECODE_BUF_BYPASS_EN
        exp_alert = 1'b1;
`else
        exp_alert = 1'b0;
`endif
        checks++;
        if (interrupt_branch_alert !== exp_alert) begin
            errors++;
            $display("FAIL alert_incoming got=%b exp=%b",
                     interrupt_branch_alert, exp_alert);
        end
        step();
        in_valid = 1'b0;
`ifdef DECODE_BUF_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_curr_pc !== 32'h80 ||
            occupancy !== 3'd0) begin
            errors++;
            $display("FAIL lat_bypass v=%b pc=%h occ=%0d exp=1/80/0",
                     out_valid, out_curr_pc, occupancy);
        end
`else
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL lat_edge1 v=%b occ=%0d exp=0/1", out_valid, occupancy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_curr_pc !== 32'h80 ||
            occupancy !== 3'd0) begin
            errors++;
            $display("FAIL lat_edge2 v=%b pc=%h occ=%0d exp=1/80/0",
                     out_valid, out_curr_pc, occupancy);
        end
`endif
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_instruction = '0;
        in_curr_pc     = '0;
        in_next_pc     = '0;
        hazard         = 1'b0;
        stall_mem      = 1'b0;
        flush          = 1'b0;
        write_enable   = 1'b0;
        write_reg      = '0;
        write_data     = '0;
        test_reset();
        test_fill_drain();
        test_regfile();
        test_hazard();
        test_flush();
        test_alert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
